// File: rtl/rpn_wnn_outgoing_repo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rpn_wnn_outgoing_repo_pkg                                                |
// | Message layout, reply constants and FSM states for the outgoing repo.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rpn_wnn_outgoing_repo_pkg;

  // Message types shared with the rest of the RPN message set
  localparam logic [7:0] RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST = 8'h30;
  localparam logic [7:0] RPN_MSG_TYPE_OUTGOING_SEQ_NUM_WRITE   = 8'h31;
  localparam logic [7:0] RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK   = 8'h32;
  localparam logic [7:0] RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY        = 8'h33;

  localparam int c_msg_type_lsb   = 0;
  localparam int c_msg_type_w     = 8;
  localparam int c_msg_index_lsb  = 8;
  localparam int c_msg_seq_lsb    = 16;
  localparam int c_msg_status_lsb = 48;
  localparam int c_msg_status_w   = 8;

  localparam int c_status_valid_bit = 0;
  localparam int c_status_match_bit = 1;

  localparam logic [63:0] c_reply_tkeep = 64'h7F;

  // tuser = {src port, dest port, IP}
  localparam int c_tuser_ip_w         = 32;
  localparam int c_tuser_port_w       = 16;
  localparam int c_tuser_dst_port_lsb = 32;
  localparam int c_tuser_src_port_lsb = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_REPLY = 2'd2
  } repo_state_e;

endpackage
`default_nettype wire

// File: rtl/rpn_wnn_outgoing_repo_seq_num_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rpn_wnn_outgoing_repo_seq_num_table                                      |
// | Single-port sequence number RAM, registered read, no reset.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rpn_wnn_outgoing_repo_seq_num_table #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/rpn_wnn_outgoing_repo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rpn_wnn_outgoing_repo                                                    |
// | Per-remote-kernel outgoing WAN sequence number store with reply path.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rpn_wnn_outgoing_repo
  import rpn_wnn_outgoing_repo_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH          = 512,
  parameter int AXIS_KEEP_WIDTH          = 64,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 64,
  parameter int SEQ_NUM_WIDTH            = 32,
  parameter int NUM_ENTRIES              = 2**AXIS_FROM_NB_TDEST_WIDTH
) (
  input  logic                                i_clk,
  input  logic                                i_ap_rst_n,
  input  logic                                from_splitter_tvalid,
  output logic                                from_splitter_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]          from_splitter_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]          from_splitter_tkeep,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_splitter_tid,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_splitter_tdest,
  input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_splitter_tuser,
  input  logic                                from_splitter_tlast,
  output logic                                to_network_bridge_tvalid,
  input  logic                                to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]          to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]          to_network_bridge_tkeep,
  output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                                to_network_bridge_tlast
);

  localparam int IDX_W = AXIS_FROM_NB_TDEST_WIDTH;

  repo_state_e                         r_state;
  logic                                r_in_tready;
  logic [NUM_ENTRIES-1:0]              r_valid;
  logic [c_msg_type_w-1:0]             r_type;
  logic [IDX_W-1:0]                    r_index;
  logic [SEQ_NUM_WIDTH-1:0]            r_seq;
  logic [IDX_W-1:0]                    r_tid;
  logic [IDX_W-1:0]                    r_tdest;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] r_tuser;

  logic                                r_out_tvalid;
  logic [AXIS_DATA_WIDTH-1:0]          r_out_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]          r_out_tkeep;
  logic [IDX_W-1:0]                    r_out_tid;
  logic [IDX_W-1:0]                    r_out_tdest;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] r_out_tuser;
  logic                                r_out_tlast;

  logic                                w_accept;
  logic [c_msg_type_w-1:0]             w_in_type;
  logic [IDX_W-1:0]                    w_in_index;
  logic [SEQ_NUM_WIDTH-1:0]            w_in_seq;
  logic                                w_is_lookup;
  logic                                w_ram_we;
  logic [SEQ_NUM_WIDTH-1:0]            w_ram_rdata;
  logic                                w_entry_valid;
  logic [c_msg_status_w-1:0]           w_status;
  logic [AXIS_DATA_WIDTH-1:0]          w_reply_tdata;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] w_reply_tuser;
  logic                                w_unused;

  assign w_accept    = from_splitter_tvalid && r_in_tready;
  assign w_in_type   = from_splitter_tdata[c_msg_type_lsb +: c_msg_type_w];
  assign w_in_index  = from_splitter_tdata[c_msg_index_lsb +: IDX_W];
  assign w_in_seq    = from_splitter_tdata[c_msg_seq_lsb +: SEQ_NUM_WIDTH];
  assign w_is_lookup = (w_in_type == RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST) ||
                       (w_in_type == RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK);
  assign w_ram_we    = w_accept && (w_in_type == RPN_MSG_TYPE_OUTGOING_SEQ_NUM_WRITE);
  assign w_unused    = ^{from_splitter_tkeep, from_splitter_tlast,
                         from_splitter_tdata[AXIS_DATA_WIDTH-1:c_msg_seq_lsb+SEQ_NUM_WIDTH]};

  // The RAM always reads the incoming index, so a lookup's data is ready in READ
  rpn_wnn_outgoing_repo_seq_num_table #(
    .DATA_WIDTH (SEQ_NUM_WIDTH),
    .ADDR_WIDTH (IDX_W),
    .DEPTH      (NUM_ENTRIES)
  ) u_seq_num_table (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_in_index),
    .i_wdata (w_in_seq),
    .o_rdata (w_ram_rdata)
  );

  assign w_entry_valid = r_valid[r_index];

  always_comb begin
    w_status = '0;
    w_status[c_status_valid_bit] = w_entry_valid;
    w_status[c_status_match_bit] = (r_type == RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK) &&
                                   w_entry_valid && (w_ram_rdata == r_seq);

    w_reply_tdata = '0;
    w_reply_tdata[c_msg_type_lsb +: c_msg_type_w]     = RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY;
    w_reply_tdata[c_msg_index_lsb +: IDX_W]           = r_index;
    w_reply_tdata[c_msg_seq_lsb +: SEQ_NUM_WIDTH]     = w_entry_valid ? w_ram_rdata : '0;
    w_reply_tdata[c_msg_status_lsb +: c_msg_status_w] = w_status;

    // Reply heads back to the sender: swap the two ports, keep the IP
    w_reply_tuser = r_tuser;
    w_reply_tuser[c_tuser_dst_port_lsb +: c_tuser_port_w] =
      r_tuser[c_tuser_src_port_lsb +: c_tuser_port_w];
    w_reply_tuser[c_tuser_src_port_lsb +: c_tuser_port_w] =
      r_tuser[c_tuser_dst_port_lsb +: c_tuser_port_w];
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_state      <= ST_IDLE;
      r_in_tready  <= 1'b0;
      r_valid      <= '0;
      r_type       <= '0;
      r_index      <= '0;
      r_seq        <= '0;
      r_tid        <= '0;
      r_tdest      <= '0;
      r_tuser      <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tkeep  <= '0;
      r_out_tid    <= '0;
      r_out_tdest  <= '0;
      r_out_tuser  <= '0;
      r_out_tlast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_tready <= 1'b1;
          if (w_accept) begin
            r_type  <= w_in_type;
            r_index <= w_in_index;
            r_seq   <= w_in_seq;
            r_tid   <= from_splitter_tid;
            r_tdest <= from_splitter_tdest;
            r_tuser <= from_splitter_tuser;
            if (w_ram_we) begin
              r_valid[w_in_index] <= 1'b1;
            end else if (w_is_lookup) begin
              r_in_tready <= 1'b0;
              r_state     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          r_out_tvalid <= 1'b1;
          r_out_tdata  <= w_reply_tdata;
          r_out_tkeep  <= AXIS_KEEP_WIDTH'(c_reply_tkeep);
          r_out_tid    <= r_tdest;
          r_out_tdest  <= r_tid;
          r_out_tuser  <= w_reply_tuser;
          r_out_tlast  <= 1'b1;
          r_state      <= ST_REPLY;
        end
        ST_REPLY: begin
          if (to_network_bridge_tready) begin
            r_out_tvalid <= 1'b0;
            r_in_tready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign from_splitter_tready     = r_in_tready;
  assign to_network_bridge_tvalid = r_out_tvalid;
  assign to_network_bridge_tdata  = r_out_tdata;
  assign to_network_bridge_tkeep  = r_out_tkeep;
  assign to_network_bridge_tid    = r_out_tid;
  assign to_network_bridge_tdest  = r_out_tdest;
  assign to_network_bridge_tuser  = r_out_tuser;
  assign to_network_bridge_tlast  = r_out_tlast;

endmodule
`default_nettype wire

// File: tb/tb_rpn_wnn_outgoing_repo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rpn_wnn_outgoing_repo                                                 |
// | Directed plus randomized bench against a table-level reference model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rpn_wnn_outgoing_repo;
  import rpn_wnn_outgoing_repo_pkg::*;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int TW = 8;
  localparam int UW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [DW-1:0] in_tdata = '0;
  logic [KW-1:0] in_tkeep = '0;
  logic [TW-1:0] in_tid = '0;
  logic [TW-1:0] in_tdest = '0;
  logic [UW-1:0] in_tuser = '0;
  logic          in_tlast = 1'b0;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [TW-1:0] out_tid;
  logic [TW-1:0] out_tdest;
  logic [UW-1:0] out_tuser;
  logic          out_tlast;

  rpn_wnn_outgoing_repo u_dut (
    .i_clk                    (clk),
    .i_ap_rst_n               (rst_n),
    .from_splitter_tvalid     (in_tvalid),
    .from_splitter_tready     (in_tready),
    .from_splitter_tdata      (in_tdata),
    .from_splitter_tkeep      (in_tkeep),
    .from_splitter_tid        (in_tid),
    .from_splitter_tdest      (in_tdest),
    .from_splitter_tuser      (in_tuser),
    .from_splitter_tlast      (in_tlast),
    .to_network_bridge_tvalid (out_tvalid),
    .to_network_bridge_tready (out_tready),
    .to_network_bridge_tdata  (out_tdata),
    .to_network_bridge_tkeep  (out_tkeep),
    .to_network_bridge_tid    (out_tid),
    .to_network_bridge_tdest  (out_tdest),
    .to_network_bridge_tuser  (out_tuser),
    .to_network_bridge_tlast  (out_tlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what each remote kernel's entry holds
  logic [31:0] m_seq   [256];
  bit          m_valid [256];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input logic [7:0] t, input logic [7:0] idx, input logic [31:0] seq,
                          input logic [7:0] tid, input logic [7:0] tdest, input logic [63:0] tuser);
    int cnt = 0;
    in_tdata          = '0;
    in_tdata[7:0]     = t;
    in_tdata[15:8]    = idx;
    in_tdata[47:16]   = seq;
    in_tdata[63:48]   = 16'($urandom);
    in_tid            = tid;
    in_tdest          = tdest;
    in_tuser          = tuser;
    in_tkeep          = {$urandom, $urandom};
    in_tlast          = 1'b1;
    in_tvalid         = 1'b1;
    while (!in_tready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (!in_tready) check_eq("in_tready_timeout", DW'(in_tready), DW'(1));
    tick();
    in_tvalid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] idx, input logic [31:0] seq);
    send_msg(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_WRITE, idx, seq, 8'($urandom), 8'($urandom),
             {$urandom, $urandom});
    m_seq[idx]   = seq;
    m_valid[idx] = 1'b1;
  endtask

  task automatic do_lookup(input logic [7:0] t, input logic [7:0] idx, input logic [31:0] seq,
                           input logic [7:0] tid, input logic [7:0] tdest,
                           input logic [63:0] tuser, input int hold);
    logic [DW-1:0] exp_d;
    logic [UW-1:0] exp_u;
    logic [31:0]   s;
    bit            v;
    v = m_valid[idx];
    s = v ? m_seq[idx] : 32'd0;
    exp_d        = '0;
    exp_d[7:0]   = RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY;
    exp_d[15:8]  = idx;
    exp_d[47:16] = s;
    exp_d[48]    = v;
    exp_d[49]    = (t == RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK) && v && (s == seq);
    exp_u        = {tuser[47:32], tuser[63:48], tuser[31:0]};
    out_tready   = 1'b0;
    send_msg(t, idx, seq, tid, tdest, tuser);
    check_eq("lat1_tvalid", DW'(out_tvalid), DW'(0));
    tick();
    check_eq("lat2_tvalid", DW'(out_tvalid), DW'(1));
    check_eq("reply_tdata", out_tdata, exp_d);
    check_eq("reply_tkeep", DW'(out_tkeep), DW'(64'h7F));
    check_eq("reply_tlast", DW'(out_tlast), DW'(1));
    check_eq("reply_tid", DW'(out_tid), DW'(tdest));
    check_eq("reply_tdest", DW'(out_tdest), DW'(tid));
    check_eq("reply_tuser", DW'(out_tuser), DW'(exp_u));
    for (int k = 0; k < hold; k++) begin
      tick();
      check_eq("hold_tvalid", DW'(out_tvalid), DW'(1));
      check_eq("hold_tdata", out_tdata, exp_d);
      check_eq("hold_in_tready", DW'(in_tready), DW'(0));
    end
    out_tready = 1'b1;
    tick();
    out_tready = 1'b0;
    check_eq("post_tvalid", DW'(out_tvalid), DW'(0));
    check_eq("post_in_tready", DW'(in_tready), DW'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  t;
    logic [7:0]  idx;
    logic [31:0] seq;

    for (int i = 0; i < 256; i++) begin
      m_seq[i]   = '0;
      m_valid[i] = 1'b0;
    end

    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_tready", DW'(in_tready), DW'(0));
    check_eq("rst_tvalid", DW'(out_tvalid), DW'(0));
    check_eq("rst_tdata", out_tdata, '0);
    check_eq("rst_tkeep", DW'(out_tkeep), DW'(0));
    check_eq("rst_tuser", DW'(out_tuser), DW'(0));
    check_eq("rst_tid_tdest_tlast", DW'({out_tid, out_tdest, out_tlast}), DW'(0));
    rst_n = 1'b1;
    tick();

    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 8'hCC, 8'hAB,
              {16'hACAC, 16'hBBBB, 32'h0C0D0E0F}, 0);

    do_write(8'hCC, 32'h12345678);
    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 8'h11, 8'h22,
              {16'h1234, 16'h5678, 32'hC0A80001}, 0);

    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK, 8'hCC, 32'h12345678, 8'h01, 8'h02,
              {16'h0001, 16'h0002, 32'h0A000001}, 0);
    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK, 8'hCC, 32'h12345679, 8'h03, 8'h04,
              {16'h0003, 16'h0004, 32'h0A000002}, 0);

    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 8'h05, 8'h06,
              {16'h0005, 16'h0006, 32'h0A000003}, 10);

    send_msg(8'hFF, 8'hCC, 32'hDEADBEEF, 8'h07, 8'h08, {16'h7, 16'h8, 32'h9});
    for (int k = 0; k < 3; k++) begin
      check_eq("unknown_no_reply", DW'(out_tvalid), DW'(0));
      check_eq("unknown_in_tready", DW'(in_tready), DW'(1));
      tick();
    end
    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK, 8'hCC, 32'h12345678, 8'h09, 8'h0A,
              {16'h0009, 16'h000A, 32'h0A000004}, 1);

    for (int i = 0; i < 60; i++) begin
      int unsigned r;
      r   = $urandom_range(0, 9);
      idx = 8'($urandom_range(0, 3) * 85);
      seq = $urandom;
      if (r < 4) begin
        do_write(idx, seq);
      end else if (r < 9) begin
        t = (r < 6) ? RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST : RPN_MSG_TYPE_OUTGOING_SEQ_NUM_CHECK;
        if ($urandom_range(0, 1) == 1) seq = m_seq[idx];
        do_lookup(t, idx, seq, 8'($urandom), 8'($urandom), {$urandom, $urandom},
                  int'($urandom_range(0, 2)));
      end else begin
        send_msg(8'hF0 | 8'($urandom_range(0, 15)), idx, seq, 8'($urandom), 8'($urandom),
                 {$urandom, $urandom});
        check_eq("rand_unknown_no_reply", DW'(out_tvalid), DW'(0));
      end
    end

    do_write(8'hCC, 32'hCAFEF00D);
    out_tready = 1'b0;
    send_msg(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 8'h10, 8'h20,
             {16'h1, 16'h2, 32'h3});
    tick();
    check_eq("pre_rst_tvalid", DW'(out_tvalid), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tvalid", DW'(out_tvalid), DW'(0));
    check_eq("midrst_tdata", out_tdata, '0);
    check_eq("midrst_in_tready", DW'(in_tready), DW'(0));
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_lookup(RPN_MSG_TYPE_OUTGOING_SEQ_NUM_REQUEST, 8'hCC, 32'h0, 8'h30, 8'h40,
              {16'h0030, 16'h0040, 32'h0B000001}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
